// File: rtl/ixc_tbexport_pkg.sv
// Shared definitions for the host-to-design export-call receiver:
// header/completion field placement, status codes and FSM state codes.
package ixc_tbexport_pkg;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_BADARGC = 2'b01;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_ARGS  = 3'd1;
   localparam state_t S_DRAIN = 3'd2;
   localparam state_t S_CALL  = 3'd3;
   localparam state_t S_WAIT  = 3'd4;
   localparam state_t S_CMP0  = 3'd5;
   localparam state_t S_CMP1  = 3'd6;

   function automatic int hdr_argc_lsb(input int fid_w);
      return fid_w;
   endfunction

   function automatic int hdr_tag_lsb(input int fid_w);
      return fid_w + 8;
   endfunction

   function automatic int cmp_status_lsb(input int fid_w, input int tag_w);
      return fid_w + tag_w;
   endfunction

   function automatic int hdr_min_dw(input int fid_w, input int tag_w);
      return fid_w + 8 + tag_w + 2;
   endfunction

endpackage

// File: rtl/ixc_tbexport_argbuf.sv
// Argument register file: indexed word write, clear-all on header accept,
// flat read-out with slot 0 in the LSBs.
module ixc_tbexport_argbuf
   import ixc_tbexport_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clr_i,
   input  logic                wr_en_i,
   input  logic [7:0]          wr_idx_i,
   input  logic [DW-1:0]       wr_data_i,
   output logic [DEPTH*DW-1:0] rd_flat_o
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_idx_i == 8'(i)) mem_q[i] <= wr_data_i;
         end
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign rd_flat_o[g*DW +: DW] = mem_q[g];
   end

endmodule

// File: rtl/ixc_tbexport_rx.sv
// Host-to-design export-call receiver: deframes call packets, presents one
// call at a time to the design and returns a two-word completion packet.
//
// state | meaning
// IDLE  | waiting for a call header from the host
// ARGS  | collecting argument words into the buffer
// DRAIN | discarding arguments of a call with too many args
// CALL  | call presented to the design, waiting for call_ready
// WAIT  | waiting for the design's return value
// CMP0  | sending completion header (status, tag, fid)
// CMP1  | sending completion return word
module ixc_tbexport_rx
   import ixc_tbexport_pkg::*;
#(
   parameter int DW       = 32,
   parameter int FID_W    = 8,
   parameter int TAG_W    = 8,
   parameter int MAX_ARGS = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   hst_valid_i,
   output logic                   hst_ready_o,
   input  logic [DW-1:0]          hst_data_i,
   output logic                   call_valid_o,
   input  logic                   call_ready_i,
   output logic [FID_W-1:0]       call_fid_o,
   output logic [7:0]             call_argc_o,
   output logic [MAX_ARGS*DW-1:0] call_args_o,
   input  logic                   ret_valid_i,
   input  logic [DW-1:0]          ret_data_i,
   output logic                   cmp_valid_o,
   input  logic                   cmp_ready_i,
   output logic [DW-1:0]          cmp_data_o,
   output logic                   busy_o
);

   localparam int         ARGC_LSB = hdr_argc_lsb(FID_W);
   localparam int         TAG_LSB  = hdr_tag_lsb(FID_W);
   localparam int         STAT_LSB = cmp_status_lsb(FID_W, TAG_W);
   localparam logic [7:0] MAX_ARGC = 8'(MAX_ARGS);

   if (hdr_min_dw(FID_W, TAG_W) > DW) begin : g_bad_dw
      $error("ixc_tbexport_rx: FID_W+8+TAG_W+2 exceeds DW");
   end
   if (MAX_ARGS < 1 || MAX_ARGS > 255) begin : g_bad_max_args
      $error("ixc_tbexport_rx: MAX_ARGS must be 1..255");
   end

   state_t             state_q, state_d;
   logic [FID_W-1:0]   fid_q, fid_d;
   logic [7:0]         argc_q, argc_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [7:0]         idx_q, idx_d;
   logic [1:0]         status_q, status_d;
   logic [DW-1:0]      ret_q, ret_d;

   logic               hst_fire;
   logic               cmp_fire;
   logic               buf_clr;
   logic               buf_wr;
   logic [7:0]         hdr_argc;
   logic               last_word;

   // Ready is gated by rst so the host sees no acceptance while reset is held.
   assign hst_ready_o  = !rst_i && (state_q == S_IDLE || state_q == S_ARGS ||
                                    state_q == S_DRAIN);
   assign call_valid_o = (state_q == S_CALL);
   assign cmp_valid_o  = (state_q == S_CMP0) || (state_q == S_CMP1);
   assign busy_o       = (state_q != S_IDLE);
   assign call_fid_o   = fid_q;
   assign call_argc_o  = argc_q;

   assign hst_fire  = hst_valid_i && hst_ready_o;
   assign cmp_fire  = cmp_valid_o && cmp_ready_i;
   assign hdr_argc  = hst_data_i[ARGC_LSB +: 8];
   assign last_word = (idx_q == argc_q - 8'd1);
   assign buf_clr   = (state_q == S_IDLE) && hst_fire;
   assign buf_wr    = (state_q == S_ARGS) && hst_fire;

   always_comb begin
      cmp_data_o = '0;
      if (state_q == S_CMP0) begin
         cmp_data_o[FID_W-1:0]      = fid_q;
         cmp_data_o[FID_W +: TAG_W] = tag_q;
         cmp_data_o[STAT_LSB +: 2]  = status_q;
      end else if (state_q == S_CMP1) begin
         cmp_data_o = ret_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      fid_d    = fid_q;
      argc_d   = argc_q;
      tag_d    = tag_q;
      idx_d    = idx_q;
      status_d = status_q;
      ret_d    = ret_q;
      case (state_q)
         S_IDLE: begin
            if (hst_fire) begin
               fid_d  = hst_data_i[FID_W-1:0];
               argc_d = hdr_argc;
               tag_d  = hst_data_i[TAG_LSB +: TAG_W];
               idx_d  = 8'd0;
               if (hdr_argc == 8'd0) begin
                  state_d = S_CALL;
               end else if (hdr_argc <= MAX_ARGC) begin
                  state_d = S_ARGS;
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_ARGS: begin
            if (hst_fire) begin
               idx_d = idx_q + 8'd1;
               if (last_word) state_d = S_CALL;
            end
         end
         S_DRAIN: begin
            if (hst_fire) begin
               idx_d = idx_q + 8'd1;
               if (last_word) begin
                  state_d  = S_CMP0;
                  status_d = ST_BADARGC;
                  ret_d    = '0;
               end
            end
         end
         S_CALL: begin
            if (call_ready_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (ret_valid_i) begin
               state_d  = S_CMP0;
               status_d = ST_OK;
               ret_d    = ret_data_i;
            end
         end
         S_CMP0: begin
            if (cmp_fire) state_d = S_CMP1;
         end
         S_CMP1: begin
            if (cmp_fire) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         fid_q    <= '0;
         argc_q   <= '0;
         tag_q    <= '0;
         idx_q    <= '0;
         status_q <= ST_OK;
         ret_q    <= '0;
      end else begin
         state_q  <= state_d;
         fid_q    <= fid_d;
         argc_q   <= argc_d;
         tag_q    <= tag_d;
         idx_q    <= idx_d;
         status_q <= status_d;
         ret_q    <= ret_d;
      end
   end

   ixc_tbexport_argbuf #(
      .DW    (DW),
      .DEPTH (MAX_ARGS)
   ) u_argbuf (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (buf_clr),
      .wr_en_i   (buf_wr),
      .wr_idx_i  (idx_q),
      .wr_data_i (hst_data_i),
      .rd_flat_o (call_args_o)
   );

endmodule

// File: tb/tb_ixc_tbexport_rx.sv
// Self-checking bench for ixc_tbexport_rx: directed packets plus randomized
// calls checked against a packet-level reference model.
module tb_ixc_tbexport_rx;

   localparam int DW       = 32;
   localparam int FID_W    = 8;
   localparam int TAG_W    = 8;
   localparam int MAX_ARGS = 4;
   localparam int AW       = MAX_ARGS * DW;

   logic              clk_sys;
   logic              rst;
   logic              hst_valid;
   logic              hst_ready;
   logic [DW-1:0]     hst_data;
   logic              call_valid;
   logic              call_ready;
   logic [FID_W-1:0]  call_fid;
   logic [7:0]        call_argc;
   logic [AW-1:0]     call_args;
   logic              ret_valid;
   logic [DW-1:0]     ret_data;
   logic              cmp_valid;
   logic              cmp_ready;
   logic [DW-1:0]     cmp_data;
   logic              busy;

   int                n_cmp;
   int                n_err;
   logic [DW-1:0]     a_args [8];

   ixc_tbexport_rx #(
      .DW       (DW),
      .FID_W    (FID_W),
      .TAG_W    (TAG_W),
      .MAX_ARGS (MAX_ARGS)
   ) u_dut (
      .clk_i        (clk_sys),
      .rst_i        (rst),
      .hst_valid_i  (hst_valid),
      .hst_ready_o  (hst_ready),
      .hst_data_i   (hst_data),
      .call_valid_o (call_valid),
      .call_ready_i (call_ready),
      .call_fid_o   (call_fid),
      .call_argc_o  (call_argc),
      .call_args_o  (call_args),
      .ret_valid_i  (ret_valid),
      .ret_data_i   (ret_data),
      .cmp_valid_o  (cmp_valid),
      .cmp_ready_i  (cmp_ready),
      .cmp_data_o   (cmp_data),
      .busy_o       (busy)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [AW-1:0] obs,
                            input logic [AW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   function automatic logic [DW-1:0] make_hdr(input logic [7:0] fid, input logic [7:0] argc,
                                              input logic [7:0] tag, input logic [7:0] junk);
      return {junk, tag, argc, fid};
   endfunction

   task automatic send_word(input logic [DW-1:0] data);
      int n;
      hst_valid = 1'b1;
      hst_data  = data;
      n = 0;
      while (!hst_ready && n < 20) begin
         tick();
         n++;
      end
      if (!hst_ready) begin
         check_val("hst_ready_timeout", hst_ready, 1'b1);
      end else begin
         tick();
      end
   endtask

   task automatic recv_word(input string name, input logic [DW-1:0] exp, input int stall);
      for (int s = 0; s < stall; s++) begin
         check_val({name, "_hold_valid"}, cmp_valid, 1'b1);
         check_val({name, "_hold_data"}, cmp_data, exp);
         check_val({name, "_hold_hst_ready"}, hst_ready, 1'b0);
         tick();
      end
      check_val({name, "_valid"}, cmp_valid, 1'b1);
      check_val({name, "_data"}, cmp_data, exp);
      cmp_ready = 1'b1;
      tick();
      cmp_ready = 1'b0;
   endtask

   // One complete host packet: header, argc words, design handshake and
   // completion. Expected behaviour comes from the packet rules alone.
   task automatic run_call(input logic [7:0] fid, input logic [7:0] argc,
                           input logic [7:0] tag, input logic [DW-1:0] ret,
                           input int stall, input bit b2b, input bit chain,
                           input logic [DW-1:0] next_hdr);
      logic [AW-1:0] exp_args;
      logic [DW-1:0] w0, w1;
      bit            bad;
      bad      = (int'(argc) > MAX_ARGS);
      exp_args = '0;
      if (!bad) begin
         for (int i = 0; i < int'(argc); i++) exp_args[i*DW +: DW] = a_args[i];
      end
      w0 = (bad ? 32'h0001_0000 : 32'h0) | (32'(tag) << 8) | 32'(fid);
      w1 = bad ? 32'h0 : ret;

      if (b2b) check_val("b2b_hdr_ready", hst_ready, 1'b1);
      send_word(make_hdr(fid, argc, tag, 8'($urandom)));
      for (int i = 0; i < int'(argc); i++) begin
         send_word(bad ? $urandom : a_args[i]);
      end
      hst_valid = 1'b0;

      if (!bad) begin
         check_val("call_latency", call_valid, 1'b1);
         check_val("call_fid", call_fid, fid);
         check_val("call_argc", call_argc, argc);
         check_val("call_args", call_args, exp_args);
         for (int s = 0; s < stall; s++) begin
            tick();
            check_val("call_hold_valid", call_valid, 1'b1);
            check_val("call_hold_args", call_args, exp_args);
            check_val("call_hold_hst_ready", hst_ready, 1'b0);
         end
         call_ready = 1'b1;
         ret_valid  = 1'b1;
         ret_data   = ~ret;
         tick();
         call_ready = 1'b0;
         ret_valid  = 1'b0;
         check_val("call_dropped", call_valid, 1'b0);
         check_val("ret_in_handshake_ignored", cmp_valid, 1'b0);
         check_val("wait_busy", busy, 1'b1);
         for (int s = 0; s < stall; s++) tick();
         check_val("wait_no_cmp", cmp_valid, 1'b0);
         ret_valid = 1'b1;
         ret_data  = ret;
         tick();
         ret_valid = 1'b0;
      end else begin
         check_val("drain_no_call", call_valid, 1'b0);
      end

      check_val("cmp0_latency", cmp_valid, 1'b1);
      recv_word("cmp0", w0, stall);
      if (chain) begin
         hst_valid = 1'b1;
         hst_data  = next_hdr;
      end
      recv_word("cmp1", w1, stall);
      check_val("idle_busy", busy, 1'b0);
      check_val("idle_no_cmp", cmp_valid, 1'b0);
   endtask

   task automatic check_reset_outputs(input string name);
      check_val({name, "_hst_ready"}, hst_ready, 1'b0);
      check_val({name, "_call_valid"}, call_valid, 1'b0);
      check_val({name, "_cmp_valid"}, cmp_valid, 1'b0);
      check_val({name, "_busy"}, busy, 1'b0);
      check_val({name, "_call_fid"}, call_fid, '0);
      check_val({name, "_call_argc"}, call_argc, '0);
      check_val({name, "_call_args"}, call_args, '0);
      check_val({name, "_cmp_data"}, cmp_data, '0);
   endtask

   initial begin
      logic [7:0]    c_fid, c_argc, c_tag, n_fid, n_argc, n_tag;
      logic [DW-1:0] c_ret, n_hdr;
      bit            c_chain, prev_chain;
      n_cmp      = 0;
      n_err      = 0;
      rst        = 1'b1;
      hst_valid  = 1'b0;
      hst_data   = '0;
      call_ready = 1'b0;
      ret_valid  = 1'b0;
      ret_data   = '0;
      cmp_ready  = 1'b0;
      #3;
      check_reset_outputs("reset");
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_val("post_reset_ready", hst_ready, 1'b1);
      check_val("post_reset_busy", busy, 1'b0);

      // Basic two-arg call with 5-cycle stalls everywhere.
      a_args[0] = 32'hAAAA_0001;
      a_args[1] = 32'hBBBB_0002;
      run_call(8'h12, 8'd2, 8'h05, 32'h0000_CAFE, 5, 1'b0, 1'b0, '0);

      run_call(8'h03, 8'd0, 8'h7F, 32'h1234_5678, 1, 1'b0, 1'b0, '0);

      run_call(8'h44, 8'd6, 8'h09, 32'hDEAD_BEEF, 2, 1'b0, 1'b0, '0);

      // Full buffer, then a short call to confirm upper slots get cleared.
      for (int i = 0; i < 4; i++) a_args[i] = $urandom;
      run_call(8'h55, 8'd4, 8'h10, $urandom, 0, 1'b0, 1'b0, '0);
      a_args[0] = 32'h0BAD_F00D;
      run_call(8'h56, 8'd1, 8'h11, $urandom, 0, 1'b0, 1'b0, '0);

      // Reset in the middle of argument collection.
      send_word(make_hdr(8'h30, 8'd3, 8'h31, 8'h00));
      send_word(32'h5757_5757);
      hst_valid = 1'b0;
      check_val("mid_args_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      tick();
      rst = 1'b0;
      #1;
      a_args[0] = 32'h0000_0021;
      run_call(8'h21, 8'd1, 8'h22, 32'h0000_0A0A, 1, 1'b0, 1'b0, '0);

      // Back-to-back with the second header waiting during CMP1.
      a_args[0] = 32'h1111_1111;
      run_call(8'h60, 8'd1, 8'hA0, 32'h6060_6060, 2, 1'b0, 1'b1,
               make_hdr(8'h61, 8'd2, 8'hA1, 8'h5A));
      a_args[0] = 32'h2222_2222;
      a_args[1] = 32'h3333_3333;
      run_call(8'h61, 8'd2, 8'hA1, 32'h6161_6161, 0, 1'b1, 1'b0, '0);

      // Randomized calls, some chained back-to-back.
      prev_chain = 1'b0;
      n_fid  = 8'($urandom);
      n_argc = 8'($urandom_range(0, 6));
      n_tag  = 8'($urandom);
      for (int k = 0; k < 30; k++) begin
         c_fid  = n_fid;
         c_argc = n_argc;
         c_tag  = n_tag;
         c_ret  = $urandom;
         for (int i = 0; i < 8; i++) a_args[i] = $urandom;
         n_fid  = 8'($urandom);
         n_argc = 8'($urandom_range(0, 6));
         n_tag  = 8'($urandom);
         n_hdr  = make_hdr(n_fid, n_argc, n_tag, 8'($urandom));
         c_chain = (k < 29) && ($urandom_range(0, 1) == 1);
         run_call(c_fid, c_argc, c_tag, c_ret, $urandom_range(0, 3),
                  prev_chain, c_chain, n_hdr);
         prev_chain = c_chain;
         if (!c_chain) begin
            for (int s = 0; s < int'($urandom_range(0, 2)); s++) tick();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
